// File: rtl/pwm_wave_generator.sv
// PWM generator with double-buffered period/high-time registers.
// New settings are adopted only at period boundaries, so no period is ever cut short or stretched.
module pwm_wave_generator #(
    parameter int WIDTH = 17
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] high_in,
    output logic             pwm_out,
    output logic             period_done,
    output logic             active
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           state, state_n;
    logic [WIDTH-1:0] pending_period, pending_high;
    logic [WIDTH-1:0] pending_period_n, pending_high_n;
    logic [WIDTH-1:0] period_q, high_q, period_n, high_n;
    logic [WIDTH-1:0] cnt, cnt_n;
    logic             boundary;
    logic             pwm_n, done_n;

    assign boundary = (state == RUN) && (cnt == period_q - ONE);

    always_comb begin
        // A load on the boundary cycle passes straight through to the next period.
        pending_period_n = load ? period_in : pending_period;
        pending_high_n   = load ? high_in   : pending_high;
        state_n  = state;
        cnt_n    = cnt;
        period_n = period_q;
        high_n   = high_q;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (enable && (period_q != '0)) begin
                    state_n = RUN;
                end else begin
                    period_n = pending_period;
                    high_n   = pending_high;
                end
            end
            RUN: begin
                if (boundary) begin
                    period_n = pending_period_n;
                    high_n   = pending_high_n;
                    cnt_n    = '0;
                    state_n  = (enable && (pending_period_n != '0)) ? RUN : IDLE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Outputs are computed from next-state values so they can be registered.
        pwm_n  = (state_n == RUN) && (cnt_n < high_n);
        done_n = (state_n == RUN) && (cnt_n == period_n - ONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            pending_period <= '0;
            pending_high   <= '0;
            period_q       <= '0;
            high_q         <= '0;
            pwm_out        <= 1'b0;
            period_done    <= 1'b0;
            active         <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            pending_period <= pending_period_n;
            pending_high   <= pending_high_n;
            period_q       <= period_n;
            high_q         <= high_n;
            pwm_out        <= pwm_n;
            period_done    <= done_n;
            active         <= (state_n == RUN);
        end
    end

endmodule

// File: tb/tb_pwm_wave_generator.sv
// Bench for pwm_wave_generator: directed vectors, a per-cycle behavioural model
// of the waveform, and literal counts of high cycles / pulses per window.
module tb_pwm_wave_generator;

    localparam int W = 17;

    logic         clk = 1'b0;
    logic         reset, enable, load;
    logic [W-1:0] period_in, high_in;
    logic         pwm_out, period_done, active;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: position inside the current period plus active/pending settings
    bit m_run;
    int m_pos, m_per, m_high, m_pp, m_ph;

    pwm_wave_generator #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .period_in(period_in), .high_in(high_in),
        .pwm_out(pwm_out), .period_done(period_done), .active(active)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d cycle=%0d", name, got, want, cyc);
        end
    endtask

    task automatic model_step();
        int np, nh;
        if (reset) begin
            m_run = 0; m_pos = 0; m_per = 0; m_high = 0; m_pp = 0; m_ph = 0;
        end else begin
            np = load ? int'(period_in) : m_pp;
            nh = load ? int'(high_in)   : m_ph;
            if (!m_run) begin
                if (enable && m_per != 0) begin
                    m_run = 1; m_pos = 0;
                end else begin
                    m_per = m_pp; m_high = m_ph;
                end
            end else if (m_pos == m_per - 1) begin
                m_per = np; m_high = nh; m_pos = 0;
                m_run = enable && (np != 0);
            end else begin
                m_pos++;
            end
            m_pp = np; m_ph = nh;
        end
    endtask

    task automatic compare();
        int e_pwm, e_done;
        e_pwm  = (m_run && m_pos < m_high) ? 1 : 0;
        e_done = (m_run && m_pos == m_per - 1) ? 1 : 0;
        if ($isunknown({pwm_out, period_done, active})) begin
            total++; bad++;
            $display("FAIL xstate got=%b%b%b want=no X cycle=%0d", pwm_out, period_done, active, cyc);
        end else begin
            check_val("pwm_out", int'(pwm_out), e_pwm);
            check_val("period_done", int'(period_done), e_done);
            check_val("active", int'(active), m_run ? 1 : 0);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare();
    endtask

    task automatic do_load(input int p, input int h);
        load = 1'b1; period_in = W'(p); high_in = W'(h);
        tick();
        load = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (1) begin
            tick();
            n++;
            if (period_done) break;
            if (n >= budget) begin
                check_val("done_timeout", n, -1);
                break;
            end
        end
    endtask

    task automatic window(input int len, output int hi, output int dn);
        hi = 0; dn = 0;
        for (int i = 0; i < len; i++) begin
            tick();
            hi += int'(pwm_out);
            dn += int'(period_done);
        end
    endtask

    initial begin
        int n, hi, dn;
        reset = 1'b1; enable = 1'b0; load = 1'b0; period_in = '0; high_in = '0;
        repeat (3) tick();
        check_val("rst_pwm", int'(pwm_out), 0);
        check_val("rst_active", int'(active), 0);
        reset = 1'b0;
        tick();

        // 10/3 basic run: 3 periods -> 9 high cycles, 3 pulses
        do_load(10, 3);
        tick();
        tick();
        enable = 1'b1;
        tick();
        check_val("first_pwm", int'(pwm_out), 1);
        window(29, hi, dn);
        check_val("run_103_high", hi + 1, 9);
        check_val("run_103_done", dn, 3);

        // mid-period reload 8/6: current period finishes, next is 8 long
        repeat (4) tick();
        do_load(8, 6);
        wait_done(20, n);
        check_val("finish_103_len", n, 5);
        window(8, hi, dn);
        check_val("p86_high", hi, 6);
        check_val("p86_done", dn, 1);

        // zero high time
        do_load(10, 0);
        wait_done(20, n);
        window(10, hi, dn);
        check_val("h0_high", hi, 0);
        check_val("h0_done", dn, 1);

        // high == period and high > period: constant 1 across wraps
        do_load(10, 10);
        wait_done(20, n);
        window(10, hi, dn);
        check_val("h10_high", hi, 10);
        do_load(10, 15);
        wait_done(20, n);
        window(20, hi, dn);
        check_val("h15_high", hi, 20);
        check_val("h15_done", dn, 2);

        // enable dropped mid-period: period completes, then idle
        do_load(10, 3);
        wait_done(20, n);
        repeat (4) tick();
        enable = 1'b0;
        wait_done(20, n);
        check_val("stop_len", n, 6);
        tick();
        check_val("stop_active", int'(active), 0);
        check_val("stop_pwm", int'(pwm_out), 0);

        // enable toggle 1->0->1 within a period has no effect
        enable = 1'b1;
        tick();
        repeat (2) tick();
        enable = 1'b0;
        tick();
        enable = 1'b1;
        wait_done(20, n);
        tick();
        check_val("toggle_active", int'(active), 1);

        // period 0 loaded while running -> idle after boundary
        do_load(0, 0);
        wait_done(20, n);
        tick();
        check_val("p0_active", int'(active), 0);
        repeat (5) tick();

        // reset exit with enable=1 and period 0 stays idle
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();
        check_val("p0_reset_active", int'(active), 0);

        // reset mid-period at cnt=2
        enable = 1'b0;
        do_load(10, 3);
        tick();
        enable = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check_val("midrst_pwm", int'(pwm_out), 0);
        check_val("midrst_done", int'(period_done), 0);
        check_val("midrst_active", int'(active), 0);
        reset = 1'b0;
        enable = 1'b0;
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pwm_wave_generator.md
PWM_WAVE_GENERATOR -- requirements
Module: pwm_wave_generator

Interface
REQ-001 Parameter WIDTH, default 17: width of the period and high-time fields; matches the duty-cycle measurement value width.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 enable  input  1  level; 1 = generate waveform, 0 = stop at the next period boundary.
REQ-005 load  input  1  single-cycle strobe; captures period_in/high_in into the pending registers.
REQ-006 period_in  input  WIDTH  requested period length in clk cycles, unsigned.
REQ-007 high_in  input  WIDTH  requested high time in clk cycles, unsigned.
REQ-008 pwm_out  output  1  generated waveform, driven directly from a flop.
REQ-009 period_done  output  1  one-cycle pulse on the last cycle of each period.
REQ-010 active  output  1  1 while the FSM is in RUN.

Function
REQ-011 Registers: pending_period/pending_high (load targets), period_q/high_q (active values), cnt[WIDTH-1:0], state in {IDLE, RUN}.
REQ-012 load=1 writes period_in/high_in into the pending registers on that edge; load is ignored during reset.
REQ-013 In IDLE, period_q/high_q copy the pending values every cycle, so loads take effect immediately.
REQ-014 IDLE -> RUN when enable=1 and period_q!=0; on that edge cnt<=0 and pwm_out<=(high_q!=0).
REQ-015 IDLE with enable=1 and period_q==0: remain in IDLE; pwm_out=0, active=0.
REQ-016 RUN: cnt increments by 1 per cycle from 0 to period_q-1, then wraps to 0; no overflow is possible since cnt < period_q <= 2^WIDTH-1.
REQ-017 RUN: pwm_out SHALL equal 1 during the cycle in which cnt<high_q; pwm_out is registered, computed from next-cnt and next-high_q, so there is no combinational path to the output.
REQ-018 Each period SHALL be exactly period_q cycles long, with exactly min(high_q, period_q) high cycles at the start of the period.
REQ-019 high_q==0 -> pwm_out constantly 0; high_q>=period_q -> pwm_out constantly 1 (100% duty, no low glitch at the wrap).
REQ-020 period_done=1 exactly in the cycle where state=RUN and cnt==period_q-1.
REQ-021 Period boundary (the cycle with period_done=1): period_q/high_q <= pending values; active values never change mid-period.
REQ-022 load in the same cycle as a boundary: the newly loaded values are used from the next period (load-through).
REQ-023 Boundary with enable=0 -> IDLE next cycle, with pwm_out<=0 and cnt<=0; enable=0 mid-period does not truncate the period.
REQ-024 Boundary where the new period_q==0 -> IDLE, with pwm_out<=0.
REQ-025 enable toggling 1->0->1 within one period: no effect; the decision is sampled only at the boundary.
REQ-026 active=1 iff state==RUN; period_done is never asserted in IDLE.

Reset
REQ-027 reset=1 on a clk edge: state<=IDLE, cnt<=0, pwm_out<=0, period_done<=0, active<=0, pending/active period and high registers <=0.
REQ-028 reset overrides enable and load in the same cycle, including mid-period; the period in progress is abandoned with no period_done pulse.
REQ-029 After reset deasserts, the block stays in IDLE until a nonzero period has been loaded and enable=1.

Verification
REQ-030 load period=10, high=3, then enable=1 -> pwm_out rises 1 cycle after enable is sampled; pattern 3 high / 7 low repeats; period_done once every 10 cycles, aligned with cnt=9.
REQ-031 Running 10/3, load 8/6 mid-period -> the current period finishes as 10/3; the next period is 8/6; no short or long period appears.
REQ-032 high=0 -> pwm_out constantly 0; high=10 or 15 with period=10 -> pwm_out constantly 1 across wraps; period_done still pulses every 10 cycles.
REQ-033 Running 10/3, deassert enable at cnt=4 -> period completes (period_done at cnt=9); then active=0 and pwm_out=0 the next cycle.
REQ-034 Running, load period=0 -> IDLE after the current boundary; enable=1 with period 0 at reset-exit -> active stays 0.
REQ-035 reset at cnt=2 of a 10/3 period -> next cycle all outputs are 0 and state is IDLE; no period_done pulse.
